// File: rtl/mult8x8_pkg.sv
// rtl/mult8x8_pkg.sv - shared widths, state encodings and shift codes for mult8x8_seq
package mult8x8_pkg;

    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LL   = 3'd1,
        ST_HL   = 3'd2,
        ST_LH   = 3'd3,
        ST_HH   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] SHIFT_0 = 2'd0;
    localparam logic [1:0] SHIFT_4 = 2'd1;
    localparam logic [1:0] SHIFT_8 = 2'd2;

    // Active-low segments, bit order g..a; blank for anything above 5.
    function automatic logic [6:0] seg7_of(input logic [2:0] val);
        case (val)
            3'd0:    seg7_of = 7'h40;
            3'd1:    seg7_of = 7'h79;
            3'd2:    seg7_of = 7'h24;
            3'd3:    seg7_of = 7'h30;
            3'd4:    seg7_of = 7'h19;
            3'd5:    seg7_of = 7'h12;
            default: seg7_of = 7'h7F;
        endcase
    endfunction

endpackage

// File: rtl/mult4x4.sv
// rtl/mult4x4.sv - combinational 4x4 -> 8 unsigned multiplier
import mult8x8_pkg::*;

module mult4x4 (
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);

    assign p = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};

endmodule

// File: rtl/mult8x8_seq.sv
// rtl/mult8x8_seq.sv - sequential 8x8 multiplier, four nibble steps; MULT_SEG7_EN adds seg output
import mult8x8_pkg::*;

module mult8x8_seq (
    input  logic              clk,
    input  logic              reset_a,
    input  logic              start,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    output logic [PROD_W-1:0] product,
    output logic              done,
    output logic              busy,
    output logic [1:0]        shift_cntrl,
    output logic [2:0]        state_out
`ifdef MULT_SEG7_EN
    ,
    output logic [6:0]        seg
`endif
);

    state_t              state, state_nxt;
    logic [OP_W-1:0]     a_q, b_q;
    logic [PROD_W-1:0]   acc_q;
    logic [NIB_W-1:0]    nib_a, nib_b;
    logic [2*NIB_W-1:0]  pp;
    logic [PROD_W-1:0]   pp_ext, pp_placed;
    logic                accept;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    always_comb begin
        state_nxt   = ST_IDLE;
        busy        = 1'b0;
        done        = 1'b0;
        shift_cntrl = SHIFT_0;
        nib_a       = a_q[NIB_W-1:0];
        nib_b       = b_q[NIB_W-1:0];
        case (state)
            ST_IDLE: state_nxt = start ? ST_LL : ST_IDLE;
            ST_LL: begin
                busy      = 1'b1;
                state_nxt = ST_HL;
            end
            ST_HL: begin
                busy        = 1'b1;
                shift_cntrl = SHIFT_4;
                nib_a       = a_q[OP_W-1:NIB_W];
                state_nxt   = ST_LH;
            end
            ST_LH: begin
                busy        = 1'b1;
                shift_cntrl = SHIFT_4;
                nib_b       = b_q[OP_W-1:NIB_W];
                state_nxt   = ST_HH;
            end
            ST_HH: begin
                busy        = 1'b1;
                shift_cntrl = SHIFT_8;
                nib_a       = a_q[OP_W-1:NIB_W];
                nib_b       = b_q[OP_W-1:NIB_W];
                state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_LL : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mult4x4 u_mult4x4 (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    assign pp_ext = {{(PROD_W-2*NIB_W){1'b0}}, pp};

    // Code 3 is never issued but places at offset 0 for safety.
    always_comb begin
        pp_placed = pp_ext;
        case (shift_cntrl)
            SHIFT_4: pp_placed = pp_ext << 4;
            SHIFT_8: pp_placed = pp_ext << 8;
            default: pp_placed = pp_ext;
        endcase
    end

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= dataa;
                b_q   <= datab;
                acc_q <= '0;
            end else if (busy) begin
                acc_q <= acc_q + pp_placed;
            end
        end
    end

    assign product   = acc_q;
    assign state_out = state;

`ifdef MULT_SEG7_EN
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            seg <= 7'h40;
        end else begin
            seg <= seg7_of(state_out);
        end
    end
`endif

endmodule

// File: tb/tb_mult8x8_seq.sv
// tb/tb_mult8x8_seq.sv - directed self-checking bench for mult8x8_seq
module tb_mult8x8_seq;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa, datab;
    logic [15:0] product;
    logic        done, busy;
    logic [1:0]  shift_cntrl;
    logic [2:0]  state_out;
`ifdef MULT_SEG7_EN
    logic [6:0]  seg;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult8x8_seq dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .product     (product),
        .done        (done),
        .busy        (busy),
        .shift_cntrl (shift_cntrl),
        .state_out   (state_out)
`ifdef MULT_SEG7_EN
        ,
        .seg         (seg)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a start, then runs until done; reports busy cycles seen.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            output logic [15:0] p, output int busy_cyc);
        bit found = 0;
        busy_cyc = 0;
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        dataa = ~a;
        datab = ~b;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                found = 1;
                break;
            end
            if (busy) busy_cyc++;
            tick();
        end
        check("done_seen", {15'd0, found}, 16'd1);
        p = product;
    endtask

    logic [15:0] p;
    int          bc;
    logic [1:0]  exp_sh [4] = '{2'd0, 2'd1, 2'd1, 2'd2};

    initial begin
        reset_a = 1'b1;
        start   = 1'b0;
        dataa   = 8'h00;
        datab   = 8'h00;
        #12;
        check("rst_state",   {13'd0, state_out}, 16'd0);
        check("rst_product", product, 16'h0000);
        check("rst_done",    {15'd0, done}, 16'd0);
        check("rst_busy",    {15'd0, busy}, 16'd0);
        check("rst_shift",   {14'd0, shift_cntrl}, 16'd0);
`ifdef MULT_SEG7_EN
        check("rst_seg",     {9'd0, seg}, 16'h0040);
`endif
        reset_a = 1'b0;
        tick();
        check("idle_hold", {13'd0, state_out}, 16'd0);

        // F4 x 12 with explicit step tracking
        dataa = 8'hF4;
        datab = 8'h12;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("seq_state", {13'd0, state_out}, 16'(i + 1));
            check("seq_shift", {14'd0, shift_cntrl}, {14'd0, exp_sh[i]});
            check("seq_busy",  {15'd0, busy}, 16'd1);
            tick();
        end
        check("f4_done",    {15'd0, done}, 16'd1);
        check("f4_state",   {13'd0, state_out}, 16'd5);
        check("f4_product", product, 16'h1128);
        check("done_shift", {14'd0, shift_cntrl}, 16'd0);
        tick();
        check("done_1cyc",  {15'd0, done}, 16'd0);
        check("back_idle",  {13'd0, state_out}, 16'd0);
        check("prod_held",  product, 16'h1128);

        run_mult(8'hFF, 8'hFF, p, bc);
        check("ff_product", p, 16'hFE01);
        check("ff_busy4",   16'(bc), 16'd4);
        tick();

        run_mult(8'h00, 8'hAB, p, bc);
        check("zero_product", p, 16'h0000);
        tick();
        run_mult(8'h0A, 8'h0B, p, bc);
        check("ab_product", p, 16'h006E);
        tick();

        // Start during HL must be ignored
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("hl_state", {13'd0, state_out}, 16'd2);
        start = 1'b1;
        dataa = 8'hFF;
        datab = 8'hFF;
        tick();
        start = 1'b0;
        check("ign_state", {13'd0, state_out}, 16'd3);
        tick();
        tick();
        check("ign_done",    {15'd0, done}, 16'd1);
        check("ign_product", product, 16'h03A8);
        tick();

        // Asynchronous reset in LH
        dataa = 8'hF4;
        datab = 8'h12;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("lh_state", {13'd0, state_out}, 16'd3);
        #2;
        reset_a = 1'b1;
        #1;
        check("ar_state",   {13'd0, state_out}, 16'd0);
        check("ar_product", product, 16'h0000);
        check("ar_busy",    {15'd0, busy}, 16'd0);
        check("ar_shift",   {14'd0, shift_cntrl}, 16'd0);
        check("ar_done",    {15'd0, done}, 16'd0);
        #1;
        reset_a = 1'b0;
        tick();
        run_mult(8'hF4, 8'h12, p, bc);
        check("post_rst_product", p, 16'h1128);
        tick();

        // Start held high: back-to-back runs
        dataa = 8'h0A;
        datab = 8'h0B;
        start = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            check("b2b_ll", {13'd0, state_out}, 16'd1);
            for (int i = 0; i < 4; i++) tick();
            check("b2b_done",    {15'd0, done}, 16'd1);
            check("b2b_product", product, 16'h006E);
`ifdef MULT_SEG7_EN
            check("seg_hh", {9'd0, seg}, 16'h0019);
`endif
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("final_idle", {13'd0, state_out}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult8x8_seq.md
# mult8x8_seq

Sequential 8x8 unsigned multiplier controller and datapath. It splits two captured 8-bit operands into nibbles, forms four 4x4 partial products over four cycles, and places each one at bit offset 0, 4 or 8 using the team's 2-bit shift code. It sums the placed products in a 16-bit accumulator. It is the initiator side of the nibble/shift-code interface and sits between the operand source and the product/display logic.

## Interface
- No parameters; all widths are fixed: 8-bit operands, 4-bit nibbles, 16-bit product.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_a  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dataa  input  8  operand A; captured when start is accepted.
- datab  input  8  operand B; captured when start is accepted.
- product  output  16  accumulator contents; valid while done=1, held until the next accepted start.
- done  output  1  high for exactly one cycle (state DONE).
- busy  output  1  high in states LL, HL, LH, HH.
- shift_cntrl  output  2  shift code of the current step: 0 = offset 0, 1 = offset 4, 2 = offset 8, 3 = offset 0 (never issued).
- state_out  output  3  encoded current state, for debug.
- seg  output  7  present only with MULT_SEG7_EN; see Configuration.

## Operation
- States and encodings: IDLE=0, LL=1, HL=2, LH=3, HH=4, DONE=5. Encodings 6 and 7 go to IDLE on the next edge.
- Start acceptance in IDLE or DONE with start=1:
  - A and B are latched.
  - The accumulator is cleared to 0.
  - Next state is LL.
- In IDLE with start=0: hold. In DONE with start=0: go to IDLE.
- Each step adds its placed partial product to the accumulator on the edge that leaves the state:
  - LL: A[3:0]*B[3:0], shift_cntrl=0 (offset 0), next HL.
  - HL: A[7:4]*B[3:0], shift_cntrl=1 (offset 4), next LH.
  - LH: A[3:0]*B[7:4], shift_cntrl=1 (offset 4), next HH.
  - HH: A[7:4]*B[7:4], shift_cntrl=2 (offset 8), next DONE.
- Widths: each partial product is 8 bits and is zero-extended to 16 bits after placement. The accumulator is 16 bits. The final sum is at most 0xFE01, so it never overflows; intermediate sums need no carry-out.
- shift_cntrl is 0 in IDLE and DONE.
- start while busy=1 is ignored. Operands are not re-latched and the sequence is not restarted.
- start in DONE gives back-to-back operation: DONE→LL with no IDLE cycle.
- Changes on dataa/datab after acceptance have no effect.
- Reset at any time, including mid-sequence, forces:
  - state IDLE;
  - accumulator, operand registers, product = 0;
  - done=0, busy=0, shift_cntrl=0, state_out=0.

## Timing
- start is high before edge E0 (in IDLE). Cycle by cycle:
  - LL, HL, LH, HH occupy cycles E0–E1, E1–E2, E2–E3, E3–E4.
  - done=1 during E4–E5.
- Latency from accepted start to done is 5 edges. The peak rate is one product every 5 cycles.
- busy, done, shift_cntrl and state_out are decoded combinationally from the state register only. They have no combinational path from any input.
- product is registered and changes only on clock edges.

## Configuration
- MULT_SEG7_EN defined:
  - Adds output seg[6:0]: an active-low seven-segment pattern (bit order g..a) of the state_out value, digits 0–5.
  - Blank (7'h7F) for encodings 6 and 7.
  - Registered, so it lags state_out by one cycle.
  - Reset value 7'h40 (digit 0).
- MULT_SEG7_EN not defined: no seg port and no decoder logic. All other behaviour is identical.

## Structure
- Shared package mult8x8_pkg holds:
  - the state encodings (IDLE…DONE, 3-bit);
  - shift code constants SHIFT_0=2'd0, SHIFT_4=2'd1, SHIFT_8=2'd2;
  - the widths 8, 4 and 16.
- One sub-module: mult4x4, a purely combinational 4-bit×4-bit→8-bit unsigned multiplier, instantiated once. The nibble muxes, placement logic, FSM and accumulator stay in the top level.

## Test plan
- A=0xF4, B=0x12, start pulse → shift_cntrl sequence 0,1,1,2; done on the 5th edge; product=0x1128.
- A=0xFF, B=0xFF → product=0xFE01; no overflow; busy high exactly 4 cycles.
- A=0x00, B=0xAB → product=0x0000, done asserted. Then A=0x0A, B=0x0B → product=0x006E.
- A=0x12, B=0x34 accepted; in HL, drive start=1 with A=0xFF, B=0xFF → start ignored; product=0x03A8.
- Start A=0xF4, B=0x12, then assert reset_a asynchronously during LH → all outputs 0 immediately, state IDLE. A new start afterwards gives 0x1128.
- A=0x0A, B=0x0B with start held high continuously → done pulses every 5 cycles with no IDLE between runs; product=0x006E each time.
